// File: rtl/game_sprite_director_pkg.sv
// Shared types and helpers for the sprite director: FSM states, direction codes
// and the mapping from a direction code to sign-extended dx/dy velocities.
package game_director_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_XY,
    LOAD_DXY,
    RUN,
    PAUSE,
    OVER
  } state_e;

  localparam logic [1:0] DIR_UR = 2'd0;
  localparam logic [1:0] DIR_UL = 2'd1;
  localparam logic [1:0] DIR_DL = 2'd2;
  localparam logic [1:0] DIR_DR = 2'd3;

  localparam int VEL_W = 16;

  function automatic logic [VEL_W-1:0] width_mask(input int width);
    logic [VEL_W-1:0] m;
    m = '0;
    for (int i = 0; i < VEL_W; i++) begin
      m[i] = (i < width);
    end
    return m;
  endfunction

  // Callers truncate the result to their own width; -1 is all ones up to `width`.
  function automatic logic [VEL_W-1:0] dir_to_dx(input logic [1:0] code, input int width);
    logic [VEL_W-1:0] v;
    v = (code == DIR_UR || code == DIR_DR) ? VEL_W'(1) : '1;
    return v & width_mask(width);
  endfunction

  function automatic logic [VEL_W-1:0] dir_to_dy(input logic [1:0] code, input int width);
    logic [VEL_W-1:0] v;
    v = (code == DIR_UR || code == DIR_UL) ? '1 : VEL_W'(1);
    return v & width_mask(width);
  endfunction

endpackage

// File: rtl/game_sprite_director_if.sv
// Key/sprite bundle between the game input logic (master) and the director (slave).
// Plain wires; no flow control beyond the one-cycle strobes it carries.
interface game_sprite_director_if #(
  parameter int DX_WIDTH = 2,
  parameter int DY_WIDTH = 2,
  parameter int W_X      = 10,
  parameter int W_Y      = 9,
  parameter int LW       = 2
);

  logic                launch_key;
  logic                dir_valid;
  logic [1:0]          dir_code;
  logic                hit_wall;
  logic                collision;
  logic                frame_start;
  logic                sprite_write_xy;
  logic                sprite_write_dxy;
  logic [W_X-1:0]      sprite_write_x;
  logic [W_Y-1:0]      sprite_write_y;
  logic [DX_WIDTH-1:0] sprite_write_dx;
  logic [DY_WIDTH-1:0] sprite_write_dy;
  logic                sprite_enable_update;
  logic [LW-1:0]       lives;
  logic                game_over;

  modport master (
    output launch_key, dir_valid, dir_code, hit_wall, collision, frame_start,
    input  sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
           sprite_write_dx, sprite_write_dy, sprite_enable_update, lives, game_over
  );

  modport slave (
    input  launch_key, dir_valid, dir_code, hit_wall, collision, frame_start,
    output sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
           sprite_write_dx, sprite_write_dy, sprite_enable_update, lives, game_over
  );

endinterface

// File: rtl/game_sprite_director_frame_counter.sv
// Counts frame_start strobes; done_o pulses combinationally on the FRAMES-th strobe.
// clr_i holds the count at zero, so a timer restarts cleanly on every entry.
module game_frame_counter #(
  parameter int FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic frame_start_i,
  output logic done_o
);

  localparam int CW = (FRAMES < 2) ? 1 : $clog2(FRAMES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(FRAMES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (frame_start_i) begin
      if (last) begin
        done_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_sprite_director.sv
// Launch/run/hit/respawn/game-over sequencer driving one sprite's write port.
// All outputs registered: a key or hit sampled at an edge shows up one cycle later.
module game_sprite_director
  import game_director_pkg::*;
#(
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 2,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int START_X       = 320,
  parameter int START_Y       = 240,
  parameter int LIVES         = 3,
  parameter int PAUSE_FRAMES  = 30,
  parameter int LW            = $clog2(LIVES + 1)
) (
  input logic                   clk,
  input logic                   rst,
  game_sprite_director_if.slave bus
);

  state_e              state_q, state_d;
  logic                launch_q;
  logic [1:0]          dir_q, dir_d;
  logic                xy_q, xy_d;
  logic                dxy_q, dxy_d;
  logic [w_x-1:0]      x_q, x_d;
  logic [w_y-1:0]      y_q, y_d;
  logic [DX_WIDTH-1:0] dx_q, dx_d;
  logic [DY_WIDTH-1:0] dy_q, dy_d;
  logic                en_q, en_d;
  logic [LW-1:0]       lives_q, lives_d;
  logic                over_q, over_d;

  logic press;
  logic hit;
  logic pause_done;

  assign press = bus.launch_key & ~launch_q;
  assign hit   = bus.hit_wall | bus.collision;
  assign dir_d = bus.dir_valid ? bus.dir_code : dir_q;

  game_frame_counter #(
    .FRAMES(PAUSE_FRAMES)
  ) u_pause_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != PAUSE),
    .frame_start_i(bus.frame_start),
    .done_o       (pause_done)
  );

  always_comb begin
    state_d = state_q;
    xy_d    = 1'b0;
    dxy_d   = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    lives_d = lives_q;

    case (state_q)
      IDLE:     if (press) state_d = LOAD_XY;
      LOAD_XY:  state_d = LOAD_DXY;
      LOAD_DXY: state_d = RUN;
      RUN: begin
        // A hit outranks a same-cycle direction change; dir_q still absorbs it.
        if (hit) begin
          if (lives_q != '0) lives_d = lives_q - LW'(1);
          state_d = (lives_q <= LW'(1)) ? OVER : PAUSE;
        end else if (bus.dir_valid) begin
          dxy_d = 1'b1;
          dx_d  = DX_WIDTH'(dir_to_dx(bus.dir_code, DX_WIDTH));
          dy_d  = DY_WIDTH'(dir_to_dy(bus.dir_code, DY_WIDTH));
        end
      end
      PAUSE:    if (pause_done) state_d = LOAD_XY;
      OVER: begin
        if (press) begin
          lives_d = LW'(LIVES);
          state_d = LOAD_XY;
        end
      end
      default:  state_d = IDLE;
    endcase

    if (state_d == LOAD_XY) begin
      xy_d = 1'b1;
      x_d  = w_x'(START_X);
      y_d  = w_y'(START_Y);
    end
    if (state_d == LOAD_DXY) begin
      dxy_d = 1'b1;
      dx_d  = DX_WIDTH'(dir_to_dx(dir_d, DX_WIDTH));
      dy_d  = DY_WIDTH'(dir_to_dy(dir_d, DY_WIDTH));
    end

    en_d   = (state_d == RUN);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      dir_q    <= '0;
      xy_q     <= 1'b0;
      dxy_q    <= 1'b0;
      x_q      <= w_x'(START_X);
      y_q      <= w_y'(START_Y);
      dx_q     <= '0;
      dy_q     <= '0;
      en_q     <= 1'b0;
      lives_q  <= LW'(LIVES);
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= bus.launch_key;
      dir_q    <= dir_d;
      xy_q     <= xy_d;
      dxy_q    <= dxy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      en_q     <= en_d;
      lives_q  <= lives_d;
      over_q   <= over_d;
    end
  end

  assign bus.sprite_write_xy      = xy_q;
  assign bus.sprite_write_dxy     = dxy_q;
  assign bus.sprite_write_x       = x_q;
  assign bus.sprite_write_y       = y_q;
  assign bus.sprite_write_dx      = dx_q;
  assign bus.sprite_write_dy      = dy_q;
  assign bus.sprite_enable_update = en_q;
  assign bus.lives                = lives_q;
  assign bus.game_over            = over_q;

endmodule

// File: tb/tb_game_sprite_director.sv
// Directed bench: stimulus pushes expected sprite writes into a scoreboard queue,
// a negedge monitor pops and compares every strobe the director emits.
module tb_game_sprite_director;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  game_sprite_director_if #(
    .DX_WIDTH(2), .DY_WIDTH(2), .W_X(10), .W_Y(9), .LW(2)
  ) bus ();

  game_sprite_director dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       kind;   // 0 = xy write, 1 = dxy write
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] dx;
    logic [1:0] dy;
    logic       en;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xy();
    sb.push_back('{kind: 1'b0, x: 10'd320, y: 9'd240, dx: 2'b00, dy: 2'b00, en: 1'b0});
  endtask

  task automatic push_dxy(input logic [1:0] dx, input logic [1:0] dy, input logic en);
    sb.push_back('{kind: 1'b1, x: 10'd0, y: 9'd0, dx: dx, dy: dy, en: en});
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_xy"},    bus.sprite_write_xy, 0);
    chk({tag, "_dxy"},   bus.sprite_write_dxy, 0);
    chk({tag, "_x"},     bus.sprite_write_x, 320);
    chk({tag, "_y"},     bus.sprite_write_y, 240);
    chk({tag, "_dx"},    bus.sprite_write_dx, 0);
    chk({tag, "_dy"},    bus.sprite_write_dy, 0);
    chk({tag, "_en"},    bus.sprite_enable_update, 0);
    chk({tag, "_lives"}, bus.lives, 3);
    chk({tag, "_over"},  bus.game_over, 0);
  endtask

  always @(negedge clk) begin
    if (bus.sprite_write_xy === 1'b1 || bus.sprite_write_dxy === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: got xy=%b dxy=%b expected no strobe (t=%0t)",
                 bus.sprite_write_xy, bus.sprite_write_dxy, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_kind", {bus.sprite_write_xy, bus.sprite_write_dxy},
            mon_e.kind ? 2'b01 : 2'b10);
        if (!mon_e.kind)
          chk("xy_pos", {bus.sprite_write_x, bus.sprite_write_y}, {mon_e.x, mon_e.y});
        else
          chk("dxy_vel", {bus.sprite_write_dx, bus.sprite_write_dy, bus.sprite_enable_update},
              {mon_e.dx, mon_e.dy, mon_e.en});
      end
    end
  end

  initial begin
    bus.launch_key  = 1'b0;
    bus.dir_valid   = 1'b0;
    bus.dir_code    = 2'd0;
    bus.hit_wall    = 1'b0;
    bus.collision   = 1'b0;
    bus.frame_start = 1'b0;

    // Reset for two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Direction accepted in IDLE, then launch
    bus.dir_valid = 1'b1;
    bus.dir_code  = 2'd3;
    tick();
    bus.dir_valid = 1'b0;
    push_xy();
    push_dxy(2'b01, 2'b01, 1'b0);
    bus.launch_key = 1'b1;
    tick();
    chk("launch_xy", bus.sprite_write_xy, 1);
    tick();
    chk("launch_en_in_dxy", bus.sprite_enable_update, 0);
    tick();
    chk("run_en", bus.sprite_enable_update, 1);
    bus.launch_key = 1'b0;

    // Direction change while running
    push_dxy(2'b11, 2'b11, 1'b1);
    bus.dir_valid = 1'b1;
    bus.dir_code  = 2'd1;
    tick();
    bus.dir_valid = 1'b0;
    chk("dir_change_en", bus.sprite_enable_update, 1);
    tick();
    chk("dir_change_en_after", bus.sprite_enable_update, 1);

    // Wall hit, then 30-frame pause
    bus.hit_wall = 1'b1;
    tick();
    bus.hit_wall = 1'b0;
    chk("hit1_en", bus.sprite_enable_update, 0);
    chk("hit1_lives", bus.lives, 2);
    frames(29);
    chk("no_early_respawn", bus.sprite_write_xy, 0);
    push_xy();
    push_dxy(2'b11, 2'b11, 1'b0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("respawn_xy", bus.sprite_write_xy, 1);
    tick();
    tick();
    chk("respawn_run_en", bus.sprite_enable_update, 1);

    // Collision together with dir_valid: hit wins, new direction used at respawn
    bus.collision = 1'b1;
    bus.dir_valid = 1'b1;
    bus.dir_code  = 2'd0;
    tick();
    bus.collision = 1'b0;
    bus.dir_valid = 1'b0;
    chk("hit2_lives", bus.lives, 1);
    chk("hit2_en", bus.sprite_enable_update, 0);
    push_xy();
    push_dxy(2'b01, 2'b11, 1'b0);
    frames(30);
    tick();
    chk("respawn2_en", bus.sprite_enable_update, 1);

    // Last life lost
    bus.hit_wall = 1'b1;
    tick();
    bus.hit_wall = 1'b0;
    chk("hit3_lives", bus.lives, 0);
    chk("hit3_over", bus.game_over, 1);
    chk("hit3_en", bus.sprite_enable_update, 0);
    bus.hit_wall = 1'b1;
    tick();
    bus.hit_wall = 1'b0;
    chk("over_hit_ignored", bus.lives, 0);
    tick();
    tick();
    tick();
    chk("over_holds", bus.game_over, 1);

    // Restart from OVER
    push_xy();
    push_dxy(2'b01, 2'b11, 1'b0);
    bus.launch_key = 1'b1;
    tick();
    chk("restart_lives", bus.lives, 3);
    chk("restart_over", bus.game_over, 0);
    tick();
    tick();
    bus.launch_key = 1'b0;
    chk("restart_en", bus.sprite_enable_update, 1);

    // Reset during PAUSE
    bus.hit_wall = 1'b1;
    tick();
    bus.hit_wall = 1'b0;
    chk("hit4_lives", bus.lives, 2);
    frames(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst_pause");

    // Reset landing on a write_xy strobe
    push_xy();
    bus.launch_key = 1'b1;
    tick();
    chk("pre_rst_xy", bus.sprite_write_xy, 1);
    rst = 1'b1;
    bus.launch_key = 1'b0;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst_strobe");
    tick();
    tick();
    tick();
    chk("idle_after_rst_en", bus.sprite_enable_update, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/game_sprite_director.md
Name: game_sprite_director

Overview:
- Drives the write side of a sprite's position/velocity interface: the strobes, coordinates, speeds and update-enable that a sprite instance consumes.
- Runs a launch / run / hit / respawn / game-over sequence from player keys, the sprite's hit_wall output and an external collision flag.
- Sits between the game top-level input logic and one sprite instance.
- Frame-paced pause uses an end-of-frame strobe from display timing.

Parameters:
- DX_WIDTH, 2: width of the sprite_write_dx output, two's complement.
- DY_WIDTH, 2: width of the sprite_write_dy output, two's complement.
- screen_width, 640: horizontal resolution.
- screen_height, 480: vertical resolution.
- w_x, $clog2(screen_width): x coordinate width.
- w_y, $clog2(screen_height): y coordinate width.
- START_X, 320: respawn x.
- START_Y, 240: respawn y.
- LIVES, 3: lives per game, must be at least 1.
- PAUSE_FRAMES, 30: frame_start strobes to wait after a hit before respawn, must be at least 1.
- LW, $clog2(LIVES+1): width of the lives output.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- launch_key  in  1  level key; the rising edge is detected internally.
- dir_valid  in  1  one-cycle strobe: a new direction is requested.
- dir_code  in  2  direction: 0 = up-right, 1 = up-left, 2 = down-left, 3 = down-right.
- hit_wall  in  1  from the sprite.
- collision  in  1  sprite overlap flag.
- frame_start  in  1  one-cycle strobe once per frame.
- sprite_write_xy  out  1  one-cycle strobe that loads x/y into the sprite.
- sprite_write_dxy  out  1  one-cycle strobe that loads dx/dy into the sprite.
- sprite_write_x  out  w_x  x value to load.
- sprite_write_y  out  w_y  y value to load.
- sprite_write_dx  out  DX_WIDTH  dx value to load.
- sprite_write_dy  out  DY_WIDTH  dy value to load.
- sprite_enable_update  out  1  lets the sprite advance its position.
- lives  out  LW  remaining lives.
- game_over  out  1  high while in OVER.

Behaviour:
- All outputs are registered. Reset values: state IDLE, both strobes 0, x = START_X, y = START_Y, dx = 0, dy = 0, enable 0, lives = LIVES, game_over 0, direction register = 0.
- Launch detection: launch_key is registered one cycle; press = launch_key & ~launch_key_q.
- Direction register: holds the last dir_code accepted in any state; it is the source of the velocity for LOAD_DXY.
- Direction mapping: dx = +1 for codes 0 and 3, otherwise -1 (all ones). dy = -1 for codes 0 and 1, otherwise +1. Values are sign-extended to DX_WIDTH / DY_WIDTH.
- IDLE: enable 0. On press → LOAD_XY.
- LOAD_XY: sprite_write_xy = 1 for exactly one cycle, with x/y = START_X/START_Y. → LOAD_DXY.
- LOAD_DXY: sprite_write_dxy = 1 for one cycle, with dx/dy mapped from the direction register. → RUN.
- RUN:
  - sprite_write_dxy is valid for the last loaded velocity, and sprite_enable_update = 1 from the first RUN cycle.
  - hit_wall | collision sampled high in cycle N: enable = 0 from cycle N+1, lives decrements in N+1, and the next state is OVER if lives was 1, else PAUSE.
  - dir_valid with no hit: one-cycle sprite_write_dxy with the new mapping in N+1; stay in RUN with enable held at 1.
  - Simultaneous hit and dir_valid: the hit wins; the direction register still updates, but no dxy strobe is issued.
- PAUSE: enable 0, and the pause counter clears on entry. Count frame_start strobes; on the PAUSE_FRAMES-th strobe → LOAD_XY. Hit inputs are ignored here.
- OVER: game_over = 1, enable 0. Hit inputs are ignored. On press: lives = LIVES, game_over = 0 → LOAD_XY.
- A press in LOAD_XY, LOAD_DXY, RUN or PAUSE is ignored.
- Strobes: never more than one strobe asserted per cycle, and never two consecutive cycles of the same strobe except as separate requests.
- Lives: lives never underflows below 0.
- Reset mid-operation: the next edge returns every output to its reset value, and any in-flight strobe drops immediately.

Decomposition:
- Package game_director_pkg holds:
  - the state enum: IDLE, LOAD_XY, LOAD_DXY, RUN, PAUSE, OVER;
  - direction code constants DIR_UR, DIR_UL, DIR_DL, DIR_DR;
  - function dir_to_dx / dir_to_dy, with the widths as arguments.
- Sub-module game_frame_counter: counts frame_start strobes up to PAUSE_FRAMES, with a clear input and a one-cycle done output. It also serves other frame-paced game timers.

Test Plan:
- Reset, hold rst for 2 cycles, then launch_key rises with dir_code = 3 accepted earlier → write_xy for exactly 1 cycle with x = 320, y = 240. The next cycle gives write_dxy with dx = 2'b01, dy = 2'b01, and enable = 1 from the cycle after.
- In RUN, dir_valid with dir_code = 1 → a single write_dxy cycle with dx = 2'b11, dy = 2'b11; enable never drops.
- In RUN, a hit_wall pulse in cycle N → enable = 0 at N+1 and lives goes 3 → 2. After exactly 30 frame_start strobes, a write_xy of 320/240 follows the 30th strobe by 1 cycle; pulses before the 30th do not respawn.
- Three hits → lives = 0 and game_over = 1. Launch stays low: no strobes. A launch rising edge → lives = 3, game_over = 0, and the LOAD_XY sequence runs.
- Same-cycle collision and dir_valid in RUN → no write_dxy; enter PAUSE. At respawn, dx/dy reflect the new dir_code.
- rst asserted during PAUSE and again in the same cycle as a write_xy strobe → the strobe drops next edge, state is IDLE, lives = 3, and all outputs match reset values.
